mod_add_seq: RTL

Chunk-serial modular adder sequencer for the butterfly datapath. It accepts two residues below the cyclotomic prime `MODULUS` through a valid/ready handshake. Each cycle it runs one `CHUNK`-bit carry-lookahead slice, and returns `(a+b) mod MODULUS` through a second valid/ready handshake. Chunk sequencing, the carry and borrow chain across cycles, and the final correction select are all owned here, so a narrow CLA slice can serve the full word width.

---
 rtl/mod_add_seq_if.sv | 32 +++
 rtl/mod_add_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/mod_add_seq_if.sv
// Operand/result handshake bundle for mod_add_seq.
// The in_op signal exists only when MOD_ADD_SEQ_SUB_EN is defined.
interface mod_add_seq_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
`ifdef MOD_ADD_SEQ_SUB_EN
    logic                  in_op;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
`ifdef MOD_ADD_SEQ_SUB_EN
        output in_op,
`endif
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
`ifdef MOD_ADD_SEQ_SUB_EN
        input  in_op,
`endif
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mod_add_seq.sv
// Chunk-serial modular adder: one CHUNK-bit slice per cycle, returns (a+b) mod MODULUS.
// Optional subtract mode ((a-b) mod MODULUS) is built only with MOD_ADD_SEQ_SUB_EN.
module mod_add_seq #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CHUNK      = 16,
    parameter logic [DATA_WIDTH-1:0] MODULUS    = 64'hFFFFFFFF00000001
) (
    input logic         clk,
    input logic         rst,
    mod_add_seq_if.slave bus
);
    localparam int N  = DATA_WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, p_q, s_q, d_q;
    logic                  c_q, w_q, sel_q;
`ifdef MOD_ADD_SEQ_SUB_EN
    logic                  op_q;
`endif

    logic [CHUNK:0]   s_ext, d_ext;
    logic             c_nx, w_nx, sel_nx, last;

    // Operand and modulus registers shift right, so the active chunk is always the low slice.
    always_comb begin
        s_ext = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
        d_ext = {1'b0, s_ext[CHUNK-1:0]} - {1'b0, p_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, w_q};
`ifdef MOD_ADD_SEQ_SUB_EN
        if (op_q) begin
            s_ext = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, c_q};
            d_ext = {1'b0, s_ext[CHUNK-1:0]} + {1'b0, p_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_q};
        end
`endif
        c_nx   = s_ext[CHUNK];
        w_nx   = d_ext[CHUNK];
        sel_nx = c_nx | ~w_nx;
`ifdef MOD_ADD_SEQ_SUB_EN
        if (op_q) sel_nx = c_nx;
`endif
    end

    assign last = (k_q == KW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            s_q   <= '0;
            d_q   <= '0;
            c_q   <= 1'b0;
            w_q   <= 1'b0;
            sel_q <= 1'b0;
`ifdef MOD_ADD_SEQ_SUB_EN
            op_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q  <= bus.in_a;
                    b_q  <= bus.in_b;
                    p_q  <= MODULUS;
                    c_q  <= 1'b0;
                    w_q  <= 1'b0;
                    k_q  <= '0;
`ifdef MOD_ADD_SEQ_SUB_EN
                    op_q <= bus.in_op;
`endif
                end
                RUN: begin
                    a_q <= a_q >> CHUNK;
                    b_q <= b_q >> CHUNK;
                    p_q <= p_q >> CHUNK;
                    s_q[k_q*CHUNK +: CHUNK] <= s_ext[CHUNK-1:0];
                    d_q[k_q*CHUNK +: CHUNK] <= d_ext[CHUNK-1:0];
                    c_q <= c_nx;
                    w_q <= w_nx;
                    k_q <= k_q + 1'b1;
                    if (last) sel_q <= sel_nx;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    // Mux of registered S/D only; nothing from the input ports reaches the outputs.
    assign bus.out_data  = sel_q ? d_q : s_q;
endmodule
